// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, default bit period, FSM states.
// Used by both the transmitter and the receiver.
package uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 5208;
    localparam int BAUD_CNT_W        = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, tick on the last count.
// Clear pins the count at zero so every state entry starts a fresh period.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    logic [BAUD_CNT_W-1:0] cnt;

    assign tick = (cnt == BAUD_CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (reset || clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + BAUD_CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: THR + TSR double buffer, 8N1 framing, LSB first.
// Line outputs are registered, so they trail the FSM state by one cycle.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [DATA_BITS-1:0] thr_data,
    output logic                 tx_data,
    output logic                 thr_empty,
    output logic                 busy,
    output logic                 tx_done
);

    uart_state_e          state, state_n;
    logic [DATA_BITS-1:0] thr;
    logic [DATA_BITS-1:0] tsr;
    logic                 thr_full;
    logic [2:0]           bit_idx;
    logic                 tick;
    logic                 load_tsr;
    logic                 shift;
    logic                 done_n;
    logic                 line_n;
    logic                 accept;

    assign thr_empty = ~thr_full;
    assign accept    = load && !thr_full;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .reset(reset),
        .clear(state == IDLE),
        .tick (tick)
    );

    always_comb begin
        state_n  = state;
        load_tsr = 1'b0;
        shift    = 1'b0;
        done_n   = 1'b0;
        line_n   = 1'b1;
        unique case (state)
            IDLE: begin
                if (thr_full) begin
                    state_n  = START;
                    load_tsr = 1'b1;
                end
            end
            START: begin
                line_n = 1'b0;
                if (tick) state_n = DATA;
            end
            DATA: begin
                line_n = tsr[0];
                if (tick) begin
                    shift = 1'b1;
                    if (bit_idx == 3'(DATA_BITS - 1)) state_n = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    done_n = 1'b1;
                    // Chain straight into the next frame when a byte waits
                    if (thr_full) begin
                        state_n  = START;
                        load_tsr = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            thr      <= '0;
            tsr      <= '0;
            thr_full <= 1'b0;
            bit_idx  <= '0;
            tx_data  <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            state   <= state_n;
            tx_data <= line_n;
            busy    <= (state != IDLE);
            tx_done <= done_n;
            if (accept) begin
                thr      <= thr_data;
                thr_full <= 1'b1;
            end else if (load_tsr) begin
                thr_full <= 1'b0;
            end
            if (load_tsr) begin
                tsr     <= thr;
                bit_idx <= '0;
            end else if (shift) begin
                tsr     <= {1'b0, tsr[DATA_BITS-1:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

endmodule

// File: doc/uart_tx_core.md
UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5208, meaning system-clock cycles per serial bit (50 MHz / 9600 baud); legal range 2..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; fixed at 8 for this revision.
REQ-003 SHALL have port clk, input, 1, system clock; all logic on the rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port load, input, 1, single-cycle request to write thr_data into the Transmitter Holding Register (THR).
REQ-006 SHALL have port thr_data, input, 8, byte to transmit, sampled only when load is accepted.
REQ-007 SHALL have port tx_data, output, 1, UART serial output; idle high; registered.
REQ-008 SHALL have port thr_empty, output, 1, high when THR can accept a byte.
REQ-009 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-010 SHALL have port tx_done, output, 1, one-cycle pulse on the last cycle of each stop bit.

Function
REQ-011 SHALL frame each byte as 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1), with no parity, each bit lasting exactly CLKS_PER_BIT cycles.
REQ-012 SHALL accept load only in a cycle where thr_empty=1: THR <= thr_data and thr_empty=0 from the next cycle.
REQ-013 SHALL silently ignore load while thr_empty=0, leaving THR and the frame in progress unchanged.
REQ-014 SHALL implement the FSM states IDLE, START, DATA, and STOP.
REQ-015 SHALL go from IDLE with THR full to START on the next edge, copying THR into the shift register (TSR) and setting thr_empty=1 on that same edge.
REQ-016 SHALL have a latency such that, from idle, load accepted at edge N gives tx_data=0 starting at edge N+2.
REQ-017 SHALL go from START to DATA after CLKS_PER_BIT cycles.
REQ-018 SHALL, in DATA, shift TSR right once per bit period, with a 3-bit bit index counting 0..7.
REQ-019 SHALL go from DATA to STOP after bit 7 completes.
REQ-020 SHALL, at the end of STOP, go to START when THR is full, with a TSR<=THR transfer and no idle cycle between frames.
REQ-021 SHALL, at the end of STOP, go to IDLE when THR is empty.
REQ-022 SHALL keep the baud counter free of any drift: it resets to 0 on every state entry and counts 0..CLKS_PER_BIT-1.
REQ-023 SHALL let a load accepted during a frame wait in THR, so that at most 2 bytes are outstanding (TSR plus THR).
REQ-024 SHALL drive tx_data=1 in IDLE and STOP, 0 in START, and TSR[0] in DATA.

Reset
REQ-025 SHALL, on reset=1 at a clock edge, force state=IDLE, tx_data=1, thr_empty=1, busy=0, tx_done=0, and clear the baud counter, bit index, TSR, and THR.
REQ-026 SHALL, when reset is asserted mid-frame, abort the frame, drop any pending THR byte, and return tx_data high on the next edge.
REQ-027 SHALL give reset priority over a simultaneous load.

Structure
REQ-028 SHALL place the FSM state encoding, DATA_BITS, and the default CLKS_PER_BIT in a shared uart_pkg include, also used by the receiver.
REQ-029 SHALL implement the bit-period counter as one sub-module, uart_baud_tick, with inputs clk, reset, and clear and output tick; the rest stays flat.

Verification
REQ-030 SHALL cover this scenario with CLKS_PER_BIT=4: load 0xA5 from idle -> tx_data = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, 40 cycles total, tx_done pulses once, and busy falls the next cycle.
REQ-031 SHALL cover back-to-back bytes: load 0x3C, then load 0xFF while the first frame is in DATA -> second start bit immediately follows the first stop bit with no extra high cycle.
REQ-032 SHALL cover overrun: with THR full, load 0x00 -> ignored, and the transmitted bytes are unchanged.
REQ-033 SHALL cover reset mid-frame: assert reset during DATA bit 3 -> next edge gives tx_data=1, busy=0, thr_empty=1, and no tx_done.
REQ-034 SHALL cover a simultaneous event: load in the same cycle as reset -> load is ignored and THR stays empty.
REQ-035 SHALL cover a loopback check: feed tx_data into the team receiver at matching baud, transmit 0x00, 0x55, 0xAA, 0xFF -> rhr_data matches each byte.
